// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Instruction-fetch sequencer. Owns the architectural PC and issues one request
// at a time to instruction memory. Each fetched word is held for decode on a
// valid/ready handshake. A taken branch (branch & zero) redirects the PC in any
// state. A fetch that is still in flight when a redirect or reset occurs is
// marked stale and its response is discarded.
//
// Parameters
//   RESET_PC        PC loaded on reset (word aligned)
//
// Ports
//   clk             clock, all state on posedge
//   rst             synchronous, active-high reset
//   imem_req_valid  fetch request valid (registered)
//   imem_req_ready  imem accepts request
//   imem_req_addr   fetch address, word aligned (registered, equals the PC)
//   imem_rsp_valid  read data valid, one per accepted request
//   imem_rsp_data   instruction word
//   branch          branch resolved this cycle
//   zero            ALU zero flag; taken = branch & zero
//   branch_dest     redirect target, bits [1:0] forced to 0
//   if_valid        fetched instruction valid to decode
//   if_ready        decode accepts
//   if_instr        fetched instruction
//   if_pc           address of if_instr
//
// Optional build macro FETCH_PERF_EN adds:
//   perf_fetch_cnt  number of decode transfers (wraps at 2^32)
//   perf_flush_cnt  number of redirect cycles (wraps at 2^32)
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        branch,
    input  logic        zero,
    input  logic [31:0] branch_dest,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic        drop_reg, drop_next;
    logic        req_valid_reg;
    logic        if_valid_reg;
    logic [31:0] if_instr_reg;
    logic [31:0] if_pc_reg;
    logic        capture;

    logic        taken;
    logic        req_fire;
    logic        xfer;
    logic [31:0] dest;
    logic        unused_dest_bits;

    assign taken            = branch & zero;
    assign req_fire         = req_valid_reg & imem_req_ready;
    assign xfer             = if_valid_reg & if_ready;
    assign dest             = {branch_dest[31:2], 2'b00};
    assign unused_dest_bits = ^branch_dest[1:0];

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        drop_next  = drop_reg;
        capture    = 1'b0;
        case (state_reg)
            REQ: begin
                // A stale fetch from before a reset may still be outstanding;
                // requests stay off until its response has been swallowed.
                if (drop_reg && imem_rsp_valid) begin
                    drop_next = 1'b0;
                end
                if (req_fire) begin
                    state_next = WAIT;
                end
                if (taken) begin
                    pc_next = dest;
                    if (req_fire) begin
                        drop_next = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    drop_next = 1'b0;
                    if (drop_reg || taken) begin
                        state_next = REQ;
                    end else begin
                        state_next = HOLD;
                        capture    = 1'b1;
                        pc_next    = pc_reg + 32'd4;
                    end
                end else if (taken) begin
                    drop_next = 1'b1;
                end
                if (taken) begin
                    pc_next = dest;
                end
            end
            HOLD: begin
                if (taken) begin
                    state_next = REQ;
                    pc_next    = dest;
                end else if (xfer) begin
                    state_next = REQ;
                end
            end
            default: begin
                state_next = REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= REQ;
            pc_reg        <= RESET_PC;
            req_valid_reg <= 1'b0;
            if_valid_reg  <= 1'b0;
            if_instr_reg  <= 32'h0;
            if_pc_reg     <= 32'h0;
            // Remember a request that imem still owes us a response for.
            drop_reg      <= ((state_reg == WAIT) && !imem_rsp_valid) ||
                             ((state_reg == REQ) && req_fire);
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            drop_reg      <= drop_next;
            req_valid_reg <= (state_next == REQ) && !drop_next;
            if_valid_reg  <= (state_next == HOLD);
            if (capture) begin
                if_instr_reg <= imem_rsp_data;
                if_pc_reg    <= pc_reg;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_reg;
    logic [31:0] perf_flush_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_reg <= 32'h0;
            perf_flush_reg <= 32'h0;
        end else begin
            if (xfer) begin
                perf_fetch_reg <= perf_fetch_reg + 32'd1;
            end
            if (taken) begin
                perf_flush_reg <= perf_flush_reg + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = perf_fetch_reg;
    assign perf_flush_cnt = perf_flush_reg;
`endif

    assign imem_req_valid = req_valid_reg;
    assign imem_req_addr  = pc_reg;
    assign if_valid       = if_valid_reg;
    assign if_instr       = if_instr_reg;
    assign if_pc          = if_pc_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Directed testbench for fetch_sequencer. A small imem model answers each
// accepted request after a programmable latency with data = addr ^ 32'hDEAD_0000.
// Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        branch;
    logic        zero;
    logic [31:0] branch_dest;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int pass_cnt  = 0;
    int check_cnt = 0;

    fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .branch         (branch),
        .zero           (zero),
        .branch_dest    (branch_dest),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // imem model with programmable latency (1 or more cycles)
    int          lat = 1;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = 32'h0;
    logic [31:0] req_log[$];
    logic [31:0] xfer_log[$];

    always @(posedge clk) begin
        imem_rsp_valid <= 1'b0;
        if (rst) begin
            pend_cnt <= 0;
        end else begin
            if (pend_cnt == 1) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= pend_addr ^ 32'hDEAD_0000;
                pend_cnt       <= 0;
            end else if (pend_cnt > 1) begin
                pend_cnt <= pend_cnt - 1;
            end
            if (imem_req_valid && imem_req_ready) begin
                req_log.push_back(imem_req_addr);
                if (lat <= 1) begin
                    imem_rsp_valid <= 1'b1;
                    imem_rsp_data  <= imem_req_addr ^ 32'hDEAD_0000;
                end else begin
                    pend_addr <= imem_req_addr;
                    pend_cnt  <= lat - 1;
                end
            end
            if (if_valid && if_ready) begin
                xfer_log.push_back(if_pc);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
            $display("check %-16s obs=%08h exp=%08h ok", tag, obs, exp);
        end else begin
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for the next if_valid, then compare pc/instr at that negedge.
    task automatic expect_fetch(input logic [31:0] exp_pc, input logic [31:0] exp_instr);
        int n = 0;
        @(negedge clk);
        while (!if_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_valid", {31'h0, if_valid}, 32'h1);
        chk("fetch_pc", if_pc, exp_pc);
        chk("fetch_instr", if_instr, exp_instr);
    endtask

    function automatic int count_xfer(input logic [31:0] pc);
        int c = 0;
        foreach (xfer_log[i]) if (xfer_log[i] == pc) c++;
        return c;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int n;
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        if_ready       = 1'b0;
        branch         = 1'b0;
        zero           = 1'b0;
        branch_dest    = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_if_valid", {31'h0, if_valid}, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
`ifdef FETCH_PERF_EN
        chk("rst_perf_fetch", perf_fetch_cnt, 32'h0);
        chk("rst_perf_flush", perf_flush_cnt, 32'h0);
`endif
        rst      = 1'b0;
        if_ready = 1'b1;

        // 1: sequential fetch, 1-cycle imem
        expect_fetch(32'h0000_0000, 32'hDEAD_0000);
        expect_fetch(32'h0000_0004, 32'hDEAD_0004);
        expect_fetch(32'h0000_0008, 32'hDEAD_0008);
        chk("req_addr0", req_log[0], 32'h0);
        chk("req_addr1", req_log[1], 32'h4);
        chk("req_addr2", req_log[2], 32'h8);
        @(negedge clk);
        if_ready = 1'b0;

        // 2: HOLD stall for 5 cycles
        expect_fetch(32'h0000_000C, 32'hDEAD_000C);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'h0, if_valid}, 32'h1);
            chk("hold_instr", if_instr, 32'hDEAD_000C);
            chk("hold_no_req", {31'h0, imem_req_valid}, 32'h0);
        end
        if_ready = 1'b1;
        lat      = 2;
        @(negedge clk);
        chk("hold_released", {31'h0, if_valid}, 32'h0);

        // 3: taken branch in WAIT, stale response dropped
        n = 0;
        while (!(imem_req_valid && imem_req_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t3_req_seen", {31'h0, imem_req_valid}, 32'h1);
        idx = req_log.size();
        @(negedge clk);
        branch      = 1'b1;
        zero        = 1'b1;
        branch_dest = 32'h0000_0103;
        @(negedge clk);
        branch = 1'b0;
        zero   = 1'b0;
        expect_fetch(32'h0000_0100, 32'hDEAD_0100);
        chk("t3_stale_addr", req_log[idx], 32'h0000_0010);
        chk("t3_redir_addr", req_log[idx + 1], 32'h0000_0100);
        chk("t3_no_stale", count_xfer(32'h0000_0010), 32'h0);

        // 4: branch without zero does not redirect
        lat         = 1;
        branch      = 1'b1;
        zero        = 1'b0;
        branch_dest = 32'h0000_0200;
        expect_fetch(32'h0000_0104, 32'hDEAD_0104);
        expect_fetch(32'h0000_0108, 32'hDEAD_0108);
        branch = 1'b0;

        // 5: redirect in HOLD with transfer in the same cycle
        expect_fetch(32'h0000_010C, 32'hDEAD_010C);
        branch      = 1'b1;
        zero        = 1'b1;
        branch_dest = 32'h0000_0300;
        @(negedge clk);
        branch = 1'b0;
        zero   = 1'b0;
        chk("t5_valid_low", {31'h0, if_valid}, 32'h0);
        expect_fetch(32'h0000_0300, 32'hDEAD_0300);
        chk("t5_once", count_xfer(32'h0000_010C), 32'h1);
        @(negedge clk);
        if_ready = 1'b0;

        // 6: redirect to top of memory, PC wraps
        expect_fetch(32'h0000_0304, 32'hDEAD_0304);
        branch      = 1'b1;
        zero        = 1'b1;
        branch_dest = 32'hFFFF_FFFE;
        @(negedge clk);
        branch = 1'b0;
        zero   = 1'b0;
        chk("t6_valid_low", {31'h0, if_valid}, 32'h0);
        chk("t6_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        if_ready = 1'b1;
        expect_fetch(32'hFFFF_FFFC, 32'h2152_FFFC);
        expect_fetch(32'h0000_0000, 32'hDEAD_0000);
        @(negedge clk);
        if_ready = 1'b0;
        chk("t6_no_304", count_xfer(32'h0000_0304), 32'h0);
        chk("xfer_total", xfer_log.size(), 32'd11);
`ifdef FETCH_PERF_EN
        chk("perf_fetch", perf_fetch_cnt, 32'd11);
        chk("perf_flush", perf_flush_cnt, 32'd3);
`endif

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
